// File: rtl/debug_mem_loader_pkg.sv
// Shared types and memory-geometry defaults for the host-side debug memory loader.
// The FSM state set lives here so the loader and its bench agree on one definition.
package debug_mem_loader_pkg;

  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 32;
  localparam int RD_LAT_DEF     = 1;
  localparam int SETTLE_CYC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_HALTED
  } state_e;

  function automatic logic state_is_busy(input state_e s);
    return (s == ST_SETTLE) || (s == ST_WRITE) || (s == ST_RD_ISSUE) ||
           (s == ST_RD_WAIT) || (s == ST_RD_RESP);
  endfunction

endpackage

// File: rtl/debug_mem_loader_rd_counter.sv
// Burst-read address/count tracker: current word address, wrapping increment,
// remaining-word down-counter and last-word flag.
module debug_rd_counter
  import debug_mem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_inc,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    // Natural ADDR_W-bit overflow gives the wrap from the top address to 0.
    addr_inc = addr_q + ADDR_W'(1);
    if (load) begin
      addr_d = load_addr;
      cnt_d  = load_len;
    end else if (step) begin
      addr_d = addr_inc;
      cnt_d  = cnt_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/debug_mem_loader.sv
// Host debug initiator for the unified memory: halts the core, then performs
// single-word writes and burst reads over port B on behalf of a host bridge.
module debug_mem_loader
  import debug_mem_loader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WR,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_WDATA,
  input  logic [ADDR_W-1:0] CMD_LEN,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic [ADDR_W-1:0] RSP_ADDR,
  input  logic              RUN_REQ,
  output logic              HLT,
  output logic [ADDR_W-1:0] DBG_ADDR,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_DIN,
  input  logic [DATA_W-1:0] MEM_DOUT,
  output logic              BUSY
);

  state_e            state_q, state_d;
  logic              hlt_q, hlt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        settle_cnt_q, settle_cnt_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;

  logic              accept;
  logic              ctr_step;
  logic [ADDR_W-1:0] ctr_addr;
  logic [ADDR_W-1:0] ctr_addr_inc;
  logic              ctr_last;

  assign CMD_READY = (state_q == ST_IDLE) || (state_q == ST_HALTED);
  assign accept    = CMD_VALID && CMD_READY;

  debug_rd_counter #(
    .ADDR_W(ADDR_W)
  ) u_rd_counter (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .load_addr(CMD_ADDR),
    .load_len (CMD_LEN),
    .step     (ctr_step),
    .addr     (ctr_addr),
    .addr_inc (ctr_addr_inc),
    .last     (ctr_last)
  );

  always_comb begin
    state_d      = state_q;
    hlt_d        = hlt_q;
    we_d         = 1'b0;
    dbg_addr_d   = dbg_addr_q;
    din_d        = din_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_addr_d   = rsp_addr_q;
    cmd_wr_d     = cmd_wr_q;
    wdata_d      = wdata_q;
    settle_cnt_d = settle_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    ctr_step     = 1'b0;

    if (accept) begin
      cmd_wr_d = CMD_WR;
      wdata_d  = CMD_WDATA;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          hlt_d        = 1'b1;
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == 8'(SETTLE_CYC - 1)) begin
          dbg_addr_d = ctr_addr;
          if (cmd_wr_q) begin
            we_d    = 1'b1;
            din_d   = wdata_q;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      ST_WRITE: begin
        state_d = ST_HALTED;
      end
      ST_RD_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (wait_cnt_q == 8'(RD_LAT - 1)) begin
          rsp_data_d  = MEM_DOUT;
          rsp_addr_d  = ctr_addr;
          rsp_valid_d = 1'b1;
          state_d     = ST_RD_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_RD_RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          if (ctr_last) begin
            state_d = ST_HALTED;
          end else begin
            ctr_step   = 1'b1;
            dbg_addr_d = ctr_addr_inc;
            state_d    = ST_RD_ISSUE;
          end
        end
      end
      ST_HALTED: begin
        // A command arriving with RUN_REQ takes priority; the run request is lost.
        if (accept) begin
          dbg_addr_d = CMD_ADDR;
          if (CMD_WR) begin
            we_d    = 1'b1;
            din_d   = CMD_WDATA;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end else if (RUN_REQ) begin
          hlt_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        hlt_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      hlt_q        <= 1'b0;
      we_q         <= 1'b0;
      dbg_addr_q   <= '0;
      din_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_addr_q   <= '0;
      cmd_wr_q     <= 1'b0;
      wdata_q      <= '0;
      settle_cnt_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      hlt_q        <= hlt_d;
      we_q         <= we_d;
      dbg_addr_q   <= dbg_addr_d;
      din_q        <= din_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_addr_q   <= rsp_addr_d;
      cmd_wr_q     <= cmd_wr_d;
      wdata_q      <= wdata_d;
      settle_cnt_q <= settle_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign HLT       = hlt_q;
  assign MEM_WE    = we_q;
  assign DBG_ADDR  = dbg_addr_q;
  assign MEM_DIN   = din_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ADDR  = rsp_addr_q;
  assign BUSY      = state_is_busy(state_q);

endmodule

// File: doc/debug_mem_loader.md
Name: debug_mem_loader

Overview:
- Host-side debug initiator for the unified instruction/data memory of the RISC computer.
- Drives the processor halt line and the debug address onto memory port B; consumes port-B read data.
- Accepts single-word write commands and burst-read commands from a host (UART/JTAG bridge) over valid/ready handshakes.
- Used to load programs and to dump memory after a run.

Parameters:
- ADDR_W, 12, memory word-address width
- DATA_W, 32, memory word width
- RD_LAT, 1, port-B read latency in cycles (address to DOUT valid)
- SETTLE_CYC, 2, cycles HLT is held before the first memory access after halting

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- CMD_VALID  in  1  host command valid
- CMD_READY  out  1  block can accept a command
- CMD_WR  in  1  1 = write one word, 0 = burst read
- CMD_ADDR  in  ADDR_W  start word address
- CMD_WDATA  in  DATA_W  write data (CMD_WR=1)
- CMD_LEN  in  ADDR_W  read word count minus one (CMD_WR=0)
- RSP_VALID  out  1  read word valid
- RSP_READY  in  1  host accepts read word
- RSP_DATA  out  DATA_W  read word
- RSP_ADDR  out  ADDR_W  address of RSP_DATA
- RUN_REQ  in  1  release halt, resume processor
- HLT  out  1  processor halt; also selects debug address on port B
- DBG_ADDR  out  ADDR_W  port-B address during halt
- MEM_WE  out  1  port-B write enable
- MEM_DIN  out  DATA_W  port-B write data
- MEM_DOUT  in  DATA_W  port-B read data
- BUSY  out  1  command in progress

Behaviour:
- Reset (asynchronous, active-high):
  - state IDLE.
  - HLT, MEM_WE, RSP_VALID and BUSY are 0.
  - CMD_READY is 1 after reset is released.
  - DBG_ADDR, MEM_DIN, RSP_DATA and RSP_ADDR are 0.
  - Reset mid-command abandons it immediately. HLT drops, so the processor restarts from its own reset.
- States: IDLE, SETTLE, WRITE, RD_ISSUE, RD_WAIT, RD_RESP, HALTED.
- CMD_READY is 1 only in IDLE and HALTED. A command is accepted on CMD_VALID & CMD_READY, and its fields are registered at acceptance.
- IDLE:
  - On acceptance, HLT goes 1 the next cycle and the state moves to SETTLE.
  - RUN_REQ is ignored.
- SETTLE: lasts exactly SETTLE_CYC cycles with MEM_WE=0, then moves to WRITE or RD_ISSUE.
- HALTED: HLT stays 1.
  - On acceptance, go directly to WRITE or RD_ISSUE (no settle).
  - Else if RUN_REQ=1, HLT goes 0 the next cycle and the state moves to IDLE.
  - If CMD_VALID and RUN_REQ arrive in the same cycle, the command wins and RUN_REQ is dropped; the host re-asserts it.
- WRITE: one cycle with DBG_ADDR=addr, MEM_DIN=wdata, MEM_WE=1, then HALTED. Exactly one write pulse per write command.
- RD_ISSUE: DBG_ADDR=addr, MEM_WE=0, then RD_WAIT.
- RD_WAIT: lasts RD_LAT cycles. On its last cycle, MEM_DOUT is captured into RSP_DATA, addr into RSP_ADDR, and RSP_VALID is set. The state moves to RD_RESP.
- RD_RESP:
  - RSP_VALID, RSP_DATA and RSP_ADDR are held stable until RSP_READY=1.
  - On the handshake RSP_VALID clears. If the remaining count is 0, go to HALTED. Otherwise decrement the count, set addr+1 (wrapping from 2^ADDR_W-1 to 0) and go to RD_ISSUE.
- Throughput: one word per RD_LAT+2 cycles with RSP_READY held 1. Latency from acceptance to first RSP_VALID is SETTLE_CYC+RD_LAT+1 from IDLE, and RD_LAT+1 from HALTED.
- CMD_LEN=2^ADDR_W-1 reads the whole memory (4096 words). The counter is ADDR_W bits and does not overflow.
- Invariants:
  - MEM_WE=1 only in WRITE, and never while HLT=0.
  - BUSY=1 in SETTLE, WRITE, RD_ISSUE, RD_WAIT and RD_RESP.
  - HLT is registered, so it is glitch-free.
  - DBG_ADDR holds its last value outside access states.

Decomposition:
- Shared package holds:
  - state enum constants
  - ADDR_W/DATA_W defaults matching the memory
  - SETTLE_CYC default
- One sub-module, debug_rd_counter: holds address increment with wrap, remaining-word down-counter and last-word flag.
- The FSM stays in the top module.

Test Plan:
- Reset, then write (addr 0x010, data 0xDEADBEEF) from IDLE -> HLT=1 one cycle after acceptance; MEM_WE pulses exactly once, two cycles later, with DBG_ADDR=0x010; state HALTED; CMD_READY=1.
- Burst read addr 0x010, LEN=3, RSP_READY=1 -> RSP_ADDR sequence 0x010..0x013; first word 0xDEADBEEF; four RSP_VALID pulses spaced 3 cycles apart; then HALTED.
- Read addr 0xFFE, LEN=3, with RSP_READY stalled 5 cycles on word 2 -> addresses 0xFFE, 0xFFF, 0x000, 0x001; RSP_DATA stable during the stall; no extra port-B reads.
- In HALTED, assert CMD_VALID and RUN_REQ together -> command executes, HLT stays 1; a later lone RUN_REQ -> HLT=0 next cycle, state IDLE.
- Assert RST during RD_RESP of a LEN=7 read -> HLT, RSP_VALID and BUSY go 0 immediately; after release CMD_READY=1, and no MEM_WE was seen throughout.
